cpu_ask2_imax_guard: RTL and testbench

//  Overcurrent guard downstream of the I_max output PIO.
//  - Compares each unsigned current sample against the 16-bit I_max threshold the PIO drives.
//  - Latches a trip after FILTER consecutive over-threshold samples. The trip drives PWM-disable.
//  - Raises an Avalon IRQ to the Nios CPU and tracks the peak sample.
//  - Register interface is an Avalon-MM slave with zero wait states and read latency 0.

---
 rtl/cpu_ask2_imax_guard_pkg.sv | 21 ++
 rtl/cpu_ask2_imax_filter.sv | 99 +++++++++
 rtl/cpu_ask2_imax_guard.sv | 105 ++++++++++
 tb/tb_cpu_ask2_imax_guard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ask2_imax_guard_pkg.sv
// Shared encodings for the I_max overcurrent guard: FSM states, register
// addresses and STATUS bit positions.
package cpu_ask2_imax_guard_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_PENDING = 2'd1,
        ST_TRIPPED = 2'd2
    } state_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_FILTER = 2'd1;
    localparam logic [1:0] REG_PEAK   = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    localparam int STS_TRIP = 0;
    localparam int STS_OVER = 1;
    localparam int STS_DIS  = 2;
    localparam int STS_CNT  = 3;

endpackage

// File: rtl/cpu_ask2_imax_filter.sv
// Consecutive-sample trip filter: FSM, over-threshold counter and the
// registered trip flag that disables the power stage.
module cpu_ask2_imax_filter
    import cpu_ask2_imax_guard_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_over,
    input  logic             i_valid,
    input  logic             i_disabled,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_filter,
    output logic             o_trip,
    output logic [CNT_W-1:0] o_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_trip;
    logic [CNT_W-1:0]   w_n;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_reach;

    // A filter length of 0 is treated as 1 so a single over sample trips.
    assign w_n       = (i_filter == '0) ? CNT_W'(1) : i_filter;
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    // >= rather than == so that shrinking FILTER mid-count trips on the next over sample.
    assign w_reach   = (w_cnt_inc >= {1'b0, w_n});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARMED: begin
                if (i_over) begin
                    if (w_n == CNT_W'(1)) begin
                        w_state_nxt = ST_TRIPPED;
                        w_cnt_nxt   = w_n;
                    end else begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (i_over) begin
                    if (w_reach) begin
                        w_state_nxt = ST_TRIPPED;
                        w_cnt_nxt   = w_n;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc[CNT_W-1:0];
                    end
                end else if (i_valid) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = '0;
                end
            end
            ST_TRIPPED: begin
                // Clear takes priority; a coincident over sample is dropped.
                if (i_clear) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_ARMED;
                w_cnt_nxt   = '0;
            end
        endcase

        // Disarmed guard: abandon any partial count but keep an existing trip.
        if (i_disabled) begin
            w_cnt_nxt = '0;
            if (r_state == ST_PENDING) begin
                w_state_nxt = ST_ARMED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
            r_trip  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trip  <= (w_state_nxt == ST_TRIPPED);
        end
    end

    assign o_trip = r_trip;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/cpu_ask2_imax_guard.sv
// Overcurrent guard behind the I_max PIO: Avalon-MM register slave, peak
// tracker and interrupt around the consecutive-sample trip filter.
module cpu_ask2_imax_guard
    import cpu_ask2_imax_guard_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 8,
    parameter int FILTER_RST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [DATA_W-1:0] i_max,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              trip
);

    logic              w_wr;
    logic              w_disabled;
    logic              w_over;
    logic              w_clear;
    logic              w_trip;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  r_filter;
    logic [DATA_W-1:0] r_peak;
    logic              r_irq_en;
    logic              r_irq;
    logic              r_last_over;
    logic              w_unused_wdata;

    assign w_wr       = chipselect & ~write_n;
    // The PIO powers up at 0, which keeps the guard disarmed until a limit is written.
    assign w_disabled = (i_max == '0);
    assign w_over     = sample_valid & (sample > i_max) & ~w_disabled;
    assign w_clear    = w_wr & (address == REG_STATUS) & writedata[STS_TRIP];

    assign w_unused_wdata = ^writedata;

    cpu_ask2_imax_filter #(
        .CNT_W (CNT_W)
    ) u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_over     (w_over),
        .i_valid    (sample_valid),
        .i_disabled (w_disabled),
        .i_clear    (w_clear),
        .i_filter   (r_filter),
        .o_trip     (w_trip),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filter    <= CNT_W'(FILTER_RST);
            r_peak      <= '0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
            r_last_over <= 1'b0;
        end else begin
            if (w_wr && (address == REG_FILTER)) begin
                r_filter <= writedata[CNT_W-1:0];
            end
            if (w_wr && (address == REG_IRQ_EN)) begin
                r_irq_en <= writedata[0];
            end
            // A PEAK write beats a same-cycle larger sample.
            if (w_wr && (address == REG_PEAK)) begin
                r_peak <= '0;
            end else if (sample_valid && (sample > r_peak)) begin
                r_peak <= sample;
            end
            if (sample_valid) begin
                r_last_over <= w_over;
            end
            r_irq <= w_trip & r_irq_en;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_STATUS: begin
                readdata[STS_TRIP]          = w_trip;
                readdata[STS_OVER]          = r_last_over;
                readdata[STS_DIS]           = w_disabled;
                readdata[STS_CNT +: CNT_W]  = w_cnt;
            end
            REG_FILTER: readdata[CNT_W-1:0]  = r_filter;
            REG_PEAK:   readdata[DATA_W-1:0] = r_peak;
            REG_IRQ_EN: readdata[0]          = r_irq_en;
            default:    readdata             = '0;
        endcase
    end

    assign trip = w_trip;
    assign irq  = r_irq;

endmodule

// File: tb/tb_cpu_ask2_imax_guard.sv
// Directed bench for cpu_ask2_imax_guard with hand-computed expectations.
module tb_cpu_ask2_imax_guard;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [15:0] i_max;
    logic [15:0] sample;
    logic        sample_valid;
    logic        trip;

    int n_vec = 0;
    int n_err = 0;

    cpu_ask2_imax_guard #(
        .DATA_W     (16),
        .CNT_W      (8),
        .FILTER_RST (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq),
        .i_max        (i_max),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trip         (trip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic send(input logic [15:0] s);
        sample       = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL reset_trip got=%0b exp=0", trip); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h004) begin n_err++; $display("FAIL reset_status got=%h exp=004", d); end
        av_read(2'd1, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL reset_filter got=%h exp=4", d); end
        av_read(2'd2, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_peak got=%h exp=0", d); end
        av_read(2'd3, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_irq_en got=%h exp=0", d); end
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        for (int i = 0; i < 20; i++) send(16'hFFFF);
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL dis_trip got=%0b exp=0", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h004) begin n_err++; $display("FAIL dis_status got=%h exp=004", d); end
        av_read(2'd2, d);
        n_vec++; if (d !== 32'hFFFF) begin n_err++; $display("FAIL dis_peak got=%h exp=ffff", d); end
        av_write(2'd2, 32'h1);
        av_read(2'd2, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL peak_clear got=%h exp=0", d); end
    endtask

    task automatic test_filter();
        logic [31:0] d;
        i_max = 16'd1000;
        for (int i = 0; i < 3; i++) send(16'd1001);
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h01A) begin n_err++; $display("FAIL filt_pending3 got=%h exp=01a", d); end
        send(16'd999);
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h000) begin n_err++; $display("FAIL filt_under got=%h exp=000", d); end
        for (int i = 0; i < 3; i++) send(16'd1001);
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL filt_7th_trip got=%0b exp=0", trip); end
        send(16'd1001);
        n_vec++; if (trip !== 1'b1) begin n_err++; $display("FAIL filt_8th_trip got=%0b exp=1", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h023) begin n_err++; $display("FAIL filt_tripped_status got=%h exp=023", d); end
    endtask

    task automatic test_irq_clear();
        logic [31:0] d;
        av_write(2'd3, 32'h1);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_lag got=%0b exp=0", irq); end
        tick();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got=%0b exp=1", irq); end
        address      = 2'd0;
        writedata    = 32'h1;
        chipselect   = 1'b1;
        write_n      = 1'b0;
        sample       = 16'd2000;
        sample_valid = 1'b1;
        tick();
        chipselect   = 1'b0;
        write_n      = 1'b1;
        sample_valid = 1'b0;
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL clear_trip got=%0b exp=0", trip); end
        av_read(2'd0, d);
        n_vec++; if ((d & 32'hFFFF_FFFD) !== 32'h0) begin n_err++; $display("FAIL clear_status got=%h exp=0 (bit1 ignored)", d); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL clear_irq_lag got=%0b exp=1", irq); end
        tick();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL clear_irq_drop got=%0b exp=0", irq); end
        av_read(2'd2, d);
        n_vec++; if (d !== 32'd2000) begin n_err++; $display("FAIL peak_2000 got=%0d exp=2000", d); end
    endtask

    task automatic test_strict_and_zero_filter();
        logic [31:0] d;
        av_write(2'd3, 32'h0);
        for (int i = 0; i < 10; i++) send(16'd1000);
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL strict_trip got=%0b exp=0", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h000) begin n_err++; $display("FAIL strict_status got=%h exp=000", d); end
        av_write(2'd1, 32'h0);
        av_read(2'd1, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL filter0_read got=%h exp=0", d); end
        send(16'd1001);
        n_vec++; if (trip !== 1'b1) begin n_err++; $display("FAIL filter0_trip got=%0b exp=1", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h00B) begin n_err++; $display("FAIL filter0_status got=%h exp=00b", d); end
        av_write(2'd0, 32'h1);
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL filter0_clear got=%0b exp=0", trip); end
    endtask

    task automatic test_filter_write_pending();
        logic [31:0] d;
        av_write(2'd1, 32'd4);
        for (int i = 0; i < 3; i++) send(16'd1001);
        av_write(2'd1, 32'd2);
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h01A) begin n_err++; $display("FAIL fw_pending got=%h exp=01a", d); end
        send(16'd1001);
        n_vec++; if (trip !== 1'b1) begin n_err++; $display("FAIL fw_trip got=%0b exp=1", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h013) begin n_err++; $display("FAIL fw_status got=%h exp=013", d); end
        av_write(2'd0, 32'h1);
    endtask

    task automatic test_peak_write_wins();
        logic [31:0] d;
        address      = 2'd2;
        writedata    = 32'h0;
        chipselect   = 1'b1;
        write_n      = 1'b0;
        sample       = 16'd3000;
        sample_valid = 1'b1;
        tick();
        chipselect   = 1'b0;
        write_n      = 1'b1;
        sample_valid = 1'b0;
        av_read(2'd2, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL peak_wr_wins got=%0d exp=0", d); end
        send(16'd500);
        av_read(2'd2, d);
        n_vec++; if (d !== 32'd500) begin n_err++; $display("FAIL peak_500 got=%0d exp=500", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        av_write(2'd1, 32'd3);
        send(16'd1001);
        send(16'd1001);
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h012) begin n_err++; $display("FAIL ar_pending got=%h exp=012", d); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL ar_pend_trip got=%0b exp=0", trip); end
        av_read(2'd0, d);
        n_vec++; if (d !== 32'h000) begin n_err++; $display("FAIL ar_pend_status got=%h exp=000", d); end
        av_read(2'd1, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL ar_pend_filter got=%0d exp=4", d); end
        reset_n = 1'b1;
        tick();
        av_write(2'd3, 32'h1);
        av_write(2'd1, 32'd1);
        send(16'd1001);
        n_vec++; if (trip !== 1'b1) begin n_err++; $display("FAIL ar_trip_set got=%0b exp=1", trip); end
        tick();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ar_irq_set got=%0b exp=1", irq); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (trip !== 1'b0) begin n_err++; $display("FAIL ar_trip_clr got=%0b exp=0", trip); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq_clr got=%0b exp=0", irq); end
        av_read(2'd1, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL ar_trip_filter got=%0d exp=4", d); end
        av_read(2'd3, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ar_irq_en got=%0d exp=0", d); end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n      = 1'b0;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'h0;
        i_max        = 16'd0;
        sample       = 16'd0;
        sample_valid = 1'b0;

        test_reset();
        test_disabled();
        test_filter();
        test_irq_clear();
        test_strict_and_zero_filter();
        test_filter_write_pending();
        test_peak_write_wins();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
